// File: rtl/multi_sprite_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multi_sprite_controller
//  Purpose  : Tracks NSPR movable sprites, resolves lowest-index hit per pixel,
//             and flags sprite overlap once per frame.
//  Revision : 1.0
// ============================================================================
module multi_sprite_controller #(
    parameter int N       = 10,
    parameter int NSPR    = 4,
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 16,
    parameter int MOV_INC = 4,
    parameter int HLIM    = 640,
    parameter int VLIM    = 480,
    parameter int WRAP    = 0,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      row,
    input  logic [N-1:0]      col,
    input  logic              frame_tick,
    input  logic [3*NSPR-1:0] motion,
    output logic              disp,
    output logic [IDW-1:0]    sprite_id,
    output logic [N-1:0]      sprite_row,
    output logic [N-1:0]      sprite_col,
    output logic              collision
);

    localparam logic signed [N+1:0] c_RMAX     = (N+2)'(VLIM - HEIGHT);
    localparam logic signed [N+1:0] c_CMAX     = (N+2)'(HLIM - WIDTH);
    localparam logic signed [N+1:0] c_INC      = (N+2)'(MOV_INC);
    localparam logic [N:0]          c_HEIGHT_X = (N+1)'(HEIGHT);
    localparam logic [N:0]          c_WIDTH_X  = (N+1)'(WIDTH);
    localparam logic [N-1:0]        c_ROW_MASK = N'(HEIGHT - 1);
    localparam logic [N-1:0]        c_COL_MASK = N'(WIDTH - 1);

    // Signed N+2 arithmetic keeps an underflow negative instead of huge.
    function automatic logic [N-1:0] f_step(
        input logic [N-1:0]        pos,
        input logic signed [N+1:0] delta,
        input logic signed [N+1:0] lim
    );
        logic signed [N+1:0] sum;
        sum = $signed({2'b00, pos}) + delta;
        if (sum < 0)
            f_step = (WRAP != 0) ? lim[N-1:0] : '0;
        else if (sum > lim)
            f_step = (WRAP != 0) ? '0 : lim[N-1:0];
        else
            f_step = sum[N-1:0];
    endfunction

    logic [N-1:0]    r_row_q [NSPR];
    logic [N-1:0]    r_col_q [NSPR];
    logic [N-1:0]    w_row_d [NSPR];
    logic [N-1:0]    w_col_d [NSPR];

    logic [NSPR-1:0] w_hit;
    logic [N-1:0]    w_off_row [NSPR];
    logic [N-1:0]    w_off_col [NSPR];
    logic            w_multi;

    logic            r_disp_q, w_disp_d;
    logic [IDW-1:0]  r_id_q, w_id_d;
    logic [N-1:0]    r_srow_q, w_srow_d;
    logic [N-1:0]    r_scol_q, w_scol_d;
    logic            r_coll_q, w_coll_d;

    always_comb begin
        for (int i = 0; i < NSPR; i++) begin
            w_row_d[i] = r_row_q[i];
            w_col_d[i] = r_col_q[i];
            if (frame_tick) begin
                case (motion[3*i +: 3])
                    3'b001:  w_row_d[i] = f_step(r_row_q[i], -c_INC, c_RMAX);
                    3'b010:  w_col_d[i] = f_step(r_col_q[i],  c_INC, c_CMAX);
                    3'b011:  w_row_d[i] = f_step(r_row_q[i],  c_INC, c_RMAX);
                    3'b100:  w_col_d[i] = f_step(r_col_q[i], -c_INC, c_CMAX);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSPR; i++) begin
            if (reset) begin
                r_row_q[i] <= '0;
                r_col_q[i] <= N'(i * 2 * WIDTH);
            end else begin
                r_row_q[i] <= w_row_d[i];
                r_col_q[i] <= w_col_d[i];
            end
        end
    end

    // Compares widened by one bit so start+size cannot wrap.
    always_comb begin
        for (int i = 0; i < NSPR; i++) begin
            w_hit[i] = ({1'b0, row} >= {1'b0, r_row_q[i]}) &&
                       ({1'b0, row} <  ({1'b0, r_row_q[i]} + c_HEIGHT_X)) &&
                       ({1'b0, col} >= {1'b0, r_col_q[i]}) &&
                       ({1'b0, col} <  ({1'b0, r_col_q[i]} + c_WIDTH_X));
            w_off_row[i] = (row - r_row_q[i]) & c_ROW_MASK;
            w_off_col[i] = (col - r_col_q[i]) & c_COL_MASK;
        end
    end

    // Descending scan so the lowest index is assigned last and wins.
    always_comb begin
        w_disp_d = 1'b0;
        w_id_d   = '0;
        w_srow_d = '0;
        w_scol_d = '0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_disp_d = 1'b1;
                w_id_d   = IDW'(i);
                w_srow_d = w_off_row[i];
                w_scol_d = w_off_col[i];
            end
        end
    end

    assign w_multi = |(w_hit & (w_hit - NSPR'(1)));

    always_comb begin
        w_coll_d = r_coll_q;
        if (frame_tick)
            w_coll_d = 1'b0;
        if (w_multi)
            w_coll_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_q <= 1'b0;
            r_id_q   <= '0;
            r_srow_q <= '0;
            r_scol_q <= '0;
            r_coll_q <= 1'b0;
        end else begin
            r_disp_q <= w_disp_d;
            r_id_q   <= w_id_d;
            r_srow_q <= w_srow_d;
            r_scol_q <= w_scol_d;
            r_coll_q <= w_coll_d;
        end
    end

    assign disp       = r_disp_q;
    assign sprite_id  = r_id_q;
    assign sprite_row = r_srow_q;
    assign sprite_col = r_scol_q;
    assign collision  = r_coll_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_sprite_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_sprite_controller
//  Purpose  : Self-checking bench for clamp and wrap builds of the sprite block.
//  Revision : 1.0
// ============================================================================
module tb_multi_sprite_controller;

    localparam int c_NSPR = 4;
    localparam int c_RMAX = 464;
    localparam int c_CMAX = 624;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  row = '0;
    logic [9:0]  col = '0;
    logic        frame_tick = 1'b0;
    logic [11:0] motion = '0;

    logic        disp_c, coll_c, disp_w, coll_w;
    logic [1:0]  id_c, id_w;
    logic [9:0]  srow_c, scol_c, srow_w, scol_w;

    int checks = 0;
    int errors = 0;

    // model state: index 0 = clamp build, 1 = wrap build
    int          mr [2][c_NSPR];
    int          mc [2][c_NSPR];
    bit          mcoll [2];
    logic [23:0] mexp [2];

    always #5 clk = ~clk;

    multi_sprite_controller #(.WRAP(0)) dut_c (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .frame_tick(frame_tick), .motion(motion),
        .disp(disp_c), .sprite_id(id_c), .sprite_row(srow_c),
        .sprite_col(scol_c), .collision(coll_c)
    );

    multi_sprite_controller #(.WRAP(1)) dut_w (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .frame_tick(frame_tick), .motion(motion),
        .disp(disp_w), .sprite_id(id_w), .sprite_row(srow_w),
        .sprite_col(scol_w), .collision(coll_w)
    );

    function automatic logic [23:0] pack(bit d, int id, int sr, int sc, bit co);
        logic [1:0] lid;
        logic [9:0] lsr, lsc;
        lid = 2'(id);
        lsr = 10'(sr);
        lsc = 10'(sc);
        return {d, lid, lsr, lsc, co};
    endfunction

    function automatic int fit(int v, int mx, bit wrap);
        if (v < 0)  return wrap ? mx : 0;
        if (v > mx) return wrap ? 0 : mx;
        return v;
    endfunction

    task automatic check_vec(string name, logic [23:0] got, logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got disp=%b id=%0d srow=%0d scol=%0d coll=%b, want disp=%b id=%0d srow=%0d scol=%0d coll=%b",
                     name, got[23], got[22:21], got[20:11], got[10:1], got[0],
                     exp[23], exp[22:21], exp[20:11], exp[10:1], exp[0]);
        end
    endtask

    // Predicts the outputs registered at the coming edge and advances positions.
    task automatic model_edge(bit rst, bit tick, logic [11:0] mot, int r, int c);
        int win, cnt, nr, nc;
        logic [2:0] code;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int i = 0; i < c_NSPR; i++) begin
                    mr[m][i] = 0;
                    mc[m][i] = i * 32;
                end
                mcoll[m] = 1'b0;
                mexp[m]  = '0;
            end else begin
                win = -1;
                cnt = 0;
                for (int i = 0; i < c_NSPR; i++) begin
                    if (r >= mr[m][i] && r < mr[m][i] + 16 &&
                        c >= mc[m][i] && c < mc[m][i] + 16) begin
                        cnt++;
                        if (win < 0) win = i;
                    end
                end
                if (cnt >= 2)  mcoll[m] = 1'b1;
                else if (tick) mcoll[m] = 1'b0;
                if (win >= 0)
                    mexp[m] = pack(1'b1, win, r - mr[m][win], c - mc[m][win], mcoll[m]);
                else
                    mexp[m] = pack(1'b0, 0, 0, 0, mcoll[m]);
                if (tick) begin
                    for (int i = 0; i < c_NSPR; i++) begin
                        code = mot[3*i +: 3];
                        nr = mr[m][i];
                        nc = mc[m][i];
                        case (code)
                            3'd1: nr -= 4;
                            3'd2: nc += 4;
                            3'd3: nr += 4;
                            3'd4: nc -= 4;
                            default: ;
                        endcase
                        mr[m][i] = fit(nr, c_RMAX, m == 1);
                        mc[m][i] = fit(nc, c_CMAX, m == 1);
                    end
                end
            end
        end
    endtask

    function automatic logic [23:0] got_c();
        return {disp_c, id_c, srow_c, scol_c, coll_c};
    endfunction

    function automatic logic [23:0] got_w();
        return {disp_w, id_w, srow_w, scol_w, coll_w};
    endfunction

    task automatic drive_cycle(bit rst, bit tick, logic [11:0] mot, int r, int c);
        @(negedge clk);
        reset      = rst;
        frame_tick = tick;
        motion     = mot;
        row        = 10'(r);
        col        = 10'(c);
        model_edge(rst, tick, mot, r, c);
        @(posedge clk);
        #1;
        check_vec("model_clamp", got_c(), mexp[0]);
        check_vec("model_wrap", got_w(), mexp[1]);
    endtask

    task automatic probe(int r, int c);
        drive_cycle(1'b0, 1'b0, 12'h000, r, c);
    endtask

    task automatic tick_n(logic [11:0] mot, int n);
        for (int k = 0; k < n; k++)
            drive_cycle(1'b0, 1'b1, mot, 300, 300);
    endtask

    typedef struct {
        int          r;
        int          c;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl [$];

    initial begin
        vec_t v;
        bit   rr, tt;

        for (int c = 28; c <= 50; c++) begin
            v.r = 0;
            v.c = c;
            v.exp = (c >= 32 && c < 48) ? pack(1'b1, 1, 0, c - 32, 1'b0)
                                        : pack(1'b0, 0, 0, 0, 1'b0);
            tbl.push_back(v);
        end
        v.r = 15; v.c = 40; v.exp = pack(1'b1, 1, 15, 8, 1'b0);  tbl.push_back(v);
        v.r = 16; v.c = 40; v.exp = pack(1'b0, 0, 0, 0, 1'b0);   tbl.push_back(v);
        v.r = 7;  v.c = 100; v.exp = pack(1'b1, 3, 7, 4, 1'b0);  tbl.push_back(v);
        v.r = 3;  v.c = 15; v.exp = pack(1'b1, 0, 3, 15, 1'b0);  tbl.push_back(v);

        // reset state and post-reset scan
        drive_cycle(1'b1, 1'b0, 12'h000, 0, 0);
        check_vec("reset_outputs", got_c(), pack(1'b0, 0, 0, 0, 1'b0));
        drive_cycle(1'b1, 1'b0, 12'h000, 0, 0);
        foreach (tbl[k]) begin
            probe(tbl[k].r, tbl[k].c);
            check_vec("scan_table", got_c(), tbl[k].exp);
        end

        // clamp at the top-left, then run down into RMAX
        tick_n(12'h001, 1);
        tick_n(12'h004, 1);
        tick_n(12'h001, 1);
        probe(0, 0);
        check_vec("clamp_origin", got_c(), pack(1'b1, 0, 0, 0, 1'b0));
        tick_n(12'h003, 20);
        probe(80, 0);
        check_vec("clamp_row80", got_c(), pack(1'b1, 0, 0, 0, 1'b0));
        probe(79, 0);
        check_vec("clamp_row79_miss", got_c(), pack(1'b0, 0, 0, 0, 1'b0));
        tick_n(12'h003, 120);
        probe(479, 15);
        check_vec("clamp_rmax_corner", got_c(), pack(1'b1, 0, 15, 15, 1'b0));
        probe(463, 0);
        check_vec("clamp_rmax_above", got_c(), pack(1'b0, 0, 0, 0, 1'b0));

        // wrap at edges
        drive_cycle(1'b1, 1'b0, 12'h000, 0, 0);
        tick_n(12'h004, 1);
        probe(0, 624);
        check_vec("wrap_left_to_cmax", got_w(), pack(1'b1, 0, 0, 0, 1'b0));
        check_vec("clamp_left_stays", got_c(), pack(1'b0, 0, 0, 0, 1'b0));
        tick_n(12'h002, 1);
        probe(0, 0);
        check_vec("wrap_right_to_zero", got_w(), pack(1'b1, 0, 0, 0, 1'b0));
        tick_n(12'h001, 1);
        probe(464, 0);
        check_vec("wrap_up_to_rmax", got_w(), pack(1'b1, 0, 0, 0, 1'b0));

        // priority and sticky collision
        drive_cycle(1'b1, 1'b0, 12'h000, 0, 0);
        tick_n(12'h020, 8);
        probe(5, 5);
        check_vec("prio_overlap", got_c(), pack(1'b1, 0, 5, 5, 1'b1));
        check_vec("prio_overlap_wrap", got_w(), pack(1'b1, 0, 5, 5, 1'b1));
        probe(300, 300);
        check_vec("coll_sticky", got_c(), pack(1'b0, 0, 0, 0, 1'b1));
        tick_n(12'h000, 1);
        check_vec("coll_cleared", got_c(), pack(1'b0, 0, 0, 0, 1'b0));

        // motion ignored without frame_tick
        drive_cycle(1'b1, 1'b0, 12'h000, 0, 0);
        for (int k = 0; k < 1000; k++)
            drive_cycle(1'b0, 1'b0, 12'h492, $urandom_range(0, 40), $urandom_range(0, 130));
        tick_n(12'h492, 1);
        probe(0, 4);
        check_vec("single_tick_plus4", got_c(), pack(1'b1, 0, 0, 0, 1'b0));
        probe(0, 3);
        check_vec("single_tick_old_col", got_c(), pack(1'b0, 0, 0, 0, 1'b0));

        // reset wins over a simultaneous tick
        tick_n(12'h6DB, 5);
        drive_cycle(1'b1, 1'b1, 12'h6DB, 5, 5);
        check_vec("reset_over_tick", got_c(), pack(1'b0, 0, 0, 0, 1'b0));
        probe(0, 32);
        check_vec("reset_pos_s1", got_c(), pack(1'b1, 1, 0, 0, 1'b0));
        probe(0, 0);
        check_vec("reset_pos_s0", got_w(), pack(1'b1, 0, 0, 0, 1'b0));

        // randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rr = ($urandom_range(0, 499) == 0);
            tt = ($urandom_range(0, 7) == 0);
            drive_cycle(rr, tt, 12'($urandom), $urandom_range(0, 511), $urandom_range(0, 700));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
